// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - update handshake and BTB write port bundle
interface btb_update_ctrl_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_pc;
  logic       upd_taken;
  logic [7:0] upd_target;
  logic       wr_en;
  logic [2:0] wr_index;
  logic       wr_clear;
  logic [7:0] wr_pc;
  logic       wr_taken;
  logic [7:0] wr_target;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  upd_ready, wr_en, wr_index, wr_clear, wr_pc, wr_taken, wr_target
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output upd_ready, wr_en, wr_index, wr_clear, wr_pc, wr_taken, wr_target
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB update queue with full-table invalidate sequencer
module btb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int SETS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  btb_update_ctrl_if.slave bus,
  input  logic             inv_req,
  input  logic             memory_stall,
  output logic             inv_busy,
  output logic [2:0]       count
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
  localparam logic [2:0] LAST_SET = 3'(SETS - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nx;
  logic [2:0]    clr_idx;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [2:0]    cnt;
  logic          push;
  logic          pop;

  logic [7:0]    q_pc     [DEPTH];
  logic          q_taken  [DEPTH];
  logic [7:0]    q_target [DEPTH];

  assign push  = bus.upd_valid & bus.upd_ready;
  assign pop   = bus.wr_en & (state == ST_RUN);
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (!memory_stall && (clr_idx == LAST_SET)) state_nx = ST_RUN;
      ST_RUN:   if (inv_req) state_nx = ST_CLEAR;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    bus.upd_ready = 1'b0;
    inv_busy      = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_clear  = 1'b0;
    bus.wr_index  = 3'd0;
    bus.wr_pc     = 8'd0;
    bus.wr_taken  = 1'b0;
    bus.wr_target = 8'd0;
    case (state)
      ST_CLEAR: begin
        inv_busy     = 1'b1;
        bus.wr_clear = 1'b1;
        bus.wr_en    = !memory_stall;
        bus.wr_index = clr_idx;
      end
      ST_RUN: begin
        // An invalidate request wins over both accepting and issuing this cycle.
        bus.upd_ready = (cnt < DEPTH_C) && !inv_req;
        bus.wr_index  = q_pc[head][4:2];
        if ((cnt != 3'd0) && !memory_stall && !inv_req) begin
          bus.wr_en     = 1'b1;
          bus.wr_pc     = q_pc[head];
          bus.wr_taken  = q_taken[head];
          bus.wr_target = q_target[head];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= 3'd0;
      head    <= '0;
      tail    <= '0;
      cnt     <= 3'd0;
    end else if (state == ST_CLEAR) begin
      if (!memory_stall) clr_idx <= (clr_idx == LAST_SET) ? 3'd0 : clr_idx + 3'd1;
    end else if (inv_req) begin
      clr_idx <= 3'd0;
      head    <= '0;
      tail    <= '0;
      cnt     <= 3'd0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      cnt <= cnt + 3'd1;
      else if (pop && !push) cnt <= cnt - 3'd1;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]     <= bus.upd_pc;
      q_taken[tail]  <= bus.upd_taken;
      q_target[tail] <= bus.upd_target;
    end
  end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, update-queue entries (power of two, at least 2).
REQ-002 SHALL have parameter SETS, default 8, BTB sets to sequence during invalidate.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port upd_valid, input, 1, resolved-branch update offered by the execute stage.
REQ-006 SHALL have port upd_ready, output, 1, update accepted this cycle when both upd_valid and upd_ready are 1.
REQ-007 SHALL have port upd_pc, input, 8, branch PC bits [7:0].
REQ-008 SHALL have port upd_taken, input, 1, resolved direction.
REQ-009 SHALL have port upd_target, input, 8, resolved target bits [7:0].
REQ-010 SHALL have port inv_req, input, 1, single-cycle request to invalidate the whole BTB.
REQ-011 SHALL have port memory_stall, input, 1, BTB write port blocked this cycle.
REQ-012 SHALL have port wr_en, output, 1, BTB write strobe.
REQ-013 SHALL have port wr_index, output, 3, BTB set index to write.
REQ-014 SHALL have port wr_clear, output, 1, write an all-zero (invalid) entry instead of update data.
REQ-015 SHALL have ports wr_pc (output, 8), wr_taken (output, 1) and wr_target (output, 8), carrying the head update payload.
REQ-016 SHALL have port inv_busy, output, 1, invalidate sequence in progress.
REQ-017 SHALL have port count, output, 3, current queue occupancy (0..DEPTH).

Function
REQ-018 SHALL implement a two-state FSM, CLEAR and RUN; rst forces CLEAR with clear index 0.
REQ-019 SHALL, in CLEAR, drive upd_ready=0 and inv_busy=1; for each cycle with memory_stall=0, drive wr_en=1, wr_clear=1, wr_index=clear index, then increment the index.
REQ-020 SHALL hold the clear index and drive wr_en=0 on any CLEAR cycle with memory_stall=1.
REQ-021 SHALL go CLEAR->RUN on the edge that completes the write of index SETS-1, with the index returning to 0.
REQ-022 SHALL ignore inv_req while in CLEAR; the sequence does not restart.
REQ-023 SHALL, in RUN, use a circular FIFO of DEPTH entries {pc, taken, target} with wrap-around head/tail pointers.
REQ-024 SHALL drive upd_ready = (state==RUN) & (count<DEPTH) & !inv_req.
REQ-025 SHALL write an accepted update to the tail; it is never issued in the cycle it is accepted (minimum latency 1 cycle to wr_en).
REQ-026 SHALL, in RUN, drive wr_en = (count!=0) & !memory_stall, wr_clear=0, wr_index=head pc[4:2], and wr_pc/wr_taken/wr_target = head entry; the head pops on that same edge.
REQ-027 SHALL allow push and pop together: count unchanged, both pointers advance; when full, no push even if a pop occurs that cycle.
REQ-028 SHALL drive wr_pc/wr_taken/wr_target to 0 whenever wr_clear=1 or wr_en=0.
REQ-029 SHALL, on inv_req=1 in RUN, discard all queued entries (count=0, pointers reset), reject any update that cycle, and enter CLEAR on the next edge; no RUN write issues that cycle.
REQ-030 SHALL update count by +1 on push only, -1 on pop only, and 0 on both or neither.

Reset
REQ-031 SHALL, on the cycle after rst=1, present: state CLEAR, clear index 0, count=0, upd_ready=0, inv_busy=1, wr_en=!memory_stall, wr_index=0, wr_clear=1.
REQ-032 SHALL, on rst asserted mid-operation (CLEAR or RUN), discard queue contents and restart the full clear sequence from index 0.

Verification
REQ-033 SHALL cover: rst 1 cycle, memory_stall=0 -> wr_clear writes idx 0..7 on 8 consecutive cycles, then inv_busy=0, upd_ready=1.
REQ-034 SHALL cover: in RUN, push pc=0x2C, taken=1, target=0x80, memory_stall=0 -> next cycle wr_en=1, wr_index=3, wr_target=0x80, count 1->0.
REQ-035 SHALL cover: memory_stall=1 held, push 5 updates -> first 4 accepted, upd_ready=0 at count=4; release stall -> 4 writes in FIFO order on 4 consecutive cycles.
REQ-036 SHALL cover: count=4 with push and pop in the same cycle -> push refused, count=3; count=2 with push+pop -> count stays 2, order preserved across pointer wrap.
REQ-037 SHALL cover: count=3, inv_req=1 with simultaneous upd_valid -> update rejected, queue emptied, next 8 unstalled cycles clear idx 0..7.
REQ-038 SHALL cover: during CLEAR at idx 4, memory_stall=1 for 2 cycles plus an inv_req -> index holds at 4, resumes at 5, sequence ends at 7 without restart.
